// File: rtl/lpcm_stream_arbiter_if.sv
// Bundle of the requester-side and driver-side handshakes of the LPCM
// stream arbiter. The "slave" view belongs to the arbiter itself; the
// "master" view belongs to the environment (sequencers plus driver).
//
// Handshake rule for both channels: an item moves on a rising clk edge
// where valid and ready are both high. A producer holds its valid and
// payload stable until that edge. The arbiter's req_ready is a
// combinational one-hot grant, and out_valid is a registered output.
interface lpcm_stream_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int GAP_W = 16
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]    req_valid;
   logic [32*N_REQ-1:0] req_sample;
   logic [32*N_REQ-1:0] req_latency;
   logic [N_REQ-1:0]    req_done;
   logic [N_REQ-1:0]    req_ready;

   logic                out_valid;
   logic [31:0]         out_sample;
   logic [GAP_W-1:0]    out_latency;
   logic [ID_W-1:0]     out_id;
   logic                out_ready;

   modport master (
      output req_valid, req_sample, req_latency, req_done, out_ready,
      input  req_ready, out_valid, out_sample, out_latency, out_id
   );

   modport slave (
      input  req_valid, req_sample, req_latency, req_done, out_ready,
      output req_ready, out_valid, out_sample, out_latency, out_id
   );
endinterface

// File: rtl/lpcm_stream_arbiter.sv
// Round-robin scheduler sharing one LPCM driver between N_REQ sample
// sequencers. One item is taken per grant, presented on the output
// handshake, and after delivery the item's (clipped) latency is spent
// as idle GAP cycles before the next grant. A sticky done flag rises
// once every requester reports done with nothing pending in ARB.
module lpcm_stream_arbiter #(
   parameter int N_REQ = 4,
   parameter int GAP_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   lpcm_stream_arbiter_if.slave bus,
   output logic [31:0]          grant_count,
   output logic                 done,
   output logic [1:0]           state_dbg
);
   localparam int ID_W = $clog2(N_REQ);
   // Largest latency representable by the gap counter.
   localparam logic [31:0] GAP_MAX = (32'd1 << GAP_W) - 32'd1;

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state;
   logic [ID_W-1:0]  ptr;
   logic [GAP_W-1:0] gap_cnt;

   logic             out_valid_q;
   logic [31:0]      out_sample_q;
   logic [GAP_W-1:0] out_latency_q;
   logic [ID_W-1:0]  out_id_q;

   logic             win_found_c;
   logic [ID_W-1:0]  win_id_c;
   logic [ID_W:0]    scan_c;
   logic [31:0]      win_sample_c;
   logic [GAP_W-1:0] win_lat_c;
   logic [N_REQ-1:0] grant_c;
   logic             grant_any_c;
   logic [ID_W-1:0]  ptr_next_c;

   // Signed 32-bit latency folded into the gap counter range:
   // negatives become zero, oversize values saturate.
   function automatic logic [GAP_W-1:0] clip_latency(input logic [31:0] lat);
      if (lat[31]) begin
         return '0;
      end else if (lat > GAP_MAX) begin
         return GAP_MAX[GAP_W-1:0];
      end else begin
         return lat[GAP_W-1:0];
      end
   endfunction

   // Circular search for the first valid requester at or after ptr.
   always_comb begin
      win_found_c = 1'b0;
      win_id_c    = '0;
      scan_c      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_c = {1'b0, ptr} + (ID_W+1)'(i);
         if (scan_c >= (ID_W+1)'(N_REQ)) begin
            scan_c = scan_c - (ID_W+1)'(N_REQ);
         end
         if (!win_found_c && bus.req_valid[scan_c[ID_W-1:0]]) begin
            win_found_c = 1'b1;
            win_id_c    = scan_c[ID_W-1:0];
         end
      end
   end

   // Payload of the winning requester, latency already clipped.
   always_comb begin
      win_sample_c = '0;
      win_lat_c    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_id_c == ID_W'(i)) begin
            win_sample_c = bus.req_sample[32*i +: 32];
            win_lat_c    = clip_latency(bus.req_latency[32*i +: 32]);
         end
      end
   end

   // One-hot grant, only in ARB with arbitration enabled and out of reset.
   always_comb begin
      grant_c     = '0;
      grant_any_c = rst_n && en && (state == ARB) && win_found_c;
      if (grant_any_c) begin
         grant_c[win_id_c] = 1'b1;
      end
      ptr_next_c = (win_id_c == ID_W'(N_REQ-1)) ? '0 : win_id_c + ID_W'(1);
   end

   // Scheduler FSM with all outputs, counters and the done flag registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ARB;
         ptr           <= '0;
         gap_cnt       <= '0;
         out_valid_q   <= 1'b0;
         out_sample_q  <= '0;
         out_latency_q <= '0;
         out_id_q      <= '0;
         grant_count   <= '0;
         done          <= 1'b0;
      end else begin
         if ((state == ARB) && (&bus.req_done) && !(|bus.req_valid)) begin
            done <= 1'b1;
         end
         case (state)
            ARB: begin
               if (grant_any_c) begin
                  out_valid_q   <= 1'b1;
                  out_sample_q  <= win_sample_c;
                  out_latency_q <= win_lat_c;
                  out_id_q      <= win_id_c;
                  ptr           <= ptr_next_c;
                  state         <= SEND;
               end
            end
            SEND: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  grant_count <= grant_count + 32'd1;
                  if (out_latency_q != '0) begin
                     gap_cnt <= out_latency_q - GAP_W'(1);
                     state   <= GAP;
                  end else begin
                     state   <= ARB;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state <= ARB;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   assign bus.req_ready   = grant_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_sample  = out_sample_q;
   assign bus.out_latency = out_latency_q;
   assign bus.out_id      = out_id_q;
   assign state_dbg       = state;

endmodule

// File: tb/tb_lpcm_stream_arbiter.sv
// Directed bench for lpcm_stream_arbiter: one task per scenario, each
// with its own inline comparisons against hand-computed values.
module tb_lpcm_stream_arbiter;
   localparam int N_REQ = 4;
   localparam int GAP_W = 16;
   localparam logic [1:0] S_ARB  = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic [31:0] grant_count;
   logic        done;
   logic [1:0]  state_dbg;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit proto_en = 1'b1;
   logic [N_REQ-1:0] prev_v = '0;
   logic [N_REQ-1:0] prev_r = '0;

   lpcm_stream_arbiter_if #(.N_REQ(N_REQ), .GAP_W(GAP_W)) bus ();

   lpcm_stream_arbiter #(.N_REQ(N_REQ), .GAP_W(GAP_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .bus         (bus),
      .grant_count (grant_count),
      .done        (done),
      .state_dbg   (state_dbg)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // A requester must keep req_valid high until it is granted.
   always @(posedge clk) begin
      if (rst_n && proto_en) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (prev_v[i] && !prev_r[i] && !bus.req_valid[i]) begin
               miscompares++;
               $display("FAIL proto_hold req%0d: req_valid=0, required 1 until granted", i);
            end
         end
      end
      prev_v <= bus.req_valid;
      prev_r <= bus.req_ready;
   end

   // Hard stop so a wedged run still reports.
   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Waits for any grant; an expired budget counts as a miscompare.
   task automatic wait_grant(input int budget, output int at_cyc);
      int n;
      n = 0;
      #1;
      while (bus.req_ready == '0 && n < budget) begin
         step();
         #1;
         n++;
      end
      vectors++;
      if (bus.req_ready == '0) begin
         miscompares++;
         $display("FAIL grant_timeout: req_ready=0 after %0d cycles, required a grant", budget);
      end
      at_cyc = cyc;
   endtask

   task automatic drain();
      int n;
      n = 0;
      step();
      while (!(state_dbg == S_ARB && !bus.out_valid) && n < 100) begin
         step();
         n++;
      end
      vectors++;
      if (state_dbg != S_ARB) begin
         miscompares++;
         $display("FAIL drain: state=%0d, required %0d", state_dbg, S_ARB);
      end
   endtask

   task automatic test_reset();
      step();
      vectors++;
      if ({bus.out_valid, bus.out_sample, bus.out_latency, bus.out_id, grant_count, done,
           bus.req_ready, state_dbg} !== '0) begin
         miscompares++;
         $display("FAIL reset_values: valid=%0b sample=%h lat=%h id=%0d cnt=%0d done=%0b rdy=%b st=%0d, required all 0",
                  bus.out_valid, bus.out_sample, bus.out_latency, bus.out_id, grant_count, done,
                  bus.req_ready, state_dbg);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int c0, c1;
      bus.req_sample[31:0]  = 32'd100;
      bus.req_latency[31:0] = 32'd3;
      bus.req_valid         = 4'b0001;
      wait_grant(8, c0);
      vectors++;
      if (bus.req_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL single_grant: req_ready=%b, required 0001", bus.req_ready);
      end
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_sample !== 32'd100 || bus.out_id !== 2'd0 ||
          bus.out_latency !== 16'd3) begin
         miscompares++;
         $display("FAIL single_out: valid=%0b sample=%0d id=%0d lat=%0d, required 1 100 0 3",
                  bus.out_valid, bus.out_sample, bus.out_id, bus.out_latency);
      end
      wait_grant(20, c1);
      vectors++;
      if (c1 - c0 != 5) begin
         miscompares++;
         $display("FAIL single_spacing: %0d cycles between grants, required 5", c1 - c0);
      end
      step();
      bus.req_valid = '0;
      drain();
   endtask

   task automatic test_round_robin();
      int c, c_prev;
      logic [3:0] exp_r;
      apply_reset();
      vectors++;
      if (grant_count !== 32'd0) begin
         miscompares++;
         $display("FAIL rr_count_reset: grant_count=%0d, required 0", grant_count);
      end
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_sample[32*i +: 32]  = 32'h1000 + i;
         bus.req_latency[32*i +: 32] = 32'd0;
      end
      bus.req_valid = 4'b1111;
      c_prev = 0;
      for (int g = 0; g < 8; g++) begin
         wait_grant(4, c);
         exp_r = 4'b0001 << (g % 4);
         vectors++;
         if (bus.req_ready !== exp_r) begin
            miscompares++;
            $display("FAIL rr_order g%0d: req_ready=%b, required %b", g, bus.req_ready, exp_r);
         end
         if (g > 0) begin
            vectors++;
            if (c - c_prev != 2) begin
               miscompares++;
               $display("FAIL rr_spacing g%0d: %0d cycles, required 2", g, c - c_prev);
            end
         end
         c_prev = c;
         step();
         vectors++;
         if (bus.out_id !== 2'(g % 4) || bus.out_sample !== 32'h1000 + 32'(g % 4)) begin
            miscompares++;
            $display("FAIL rr_out g%0d: id=%0d sample=%h, required %0d %h",
                     g, bus.out_id, bus.out_sample, g % 4, 32'h1000 + 32'(g % 4));
         end
      end
      step();
      vectors++;
      if (grant_count !== 32'd8 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rr_count: grant_count=%0d out_valid=%0b, required 8 0", grant_count, bus.out_valid);
      end
      proto_en = 1'b0;
      bus.req_valid = '0;
      step();
      step();
      proto_en = 1'b1;
   endtask

   task automatic test_stall();
      int c;
      bus.out_ready = 1'b0;
      bus.req_sample[63:32] = 32'hABCD_0001;
      bus.req_sample[95:64] = 32'hABCD_0002;
      bus.req_valid = 4'b0110;
      wait_grant(4, c);
      vectors++;
      if (bus.req_ready !== 4'b0010) begin
         miscompares++;
         $display("FAIL stall_grant: req_ready=%b, required 0010", bus.req_ready);
      end
      step();
      bus.req_valid = 4'b0100;
      for (int k = 0; k < 10; k++) begin
         #1;
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.out_sample !== 32'hABCD_0001 || bus.out_id !== 2'd1 ||
             bus.req_ready !== 4'b0000 || grant_count !== 32'd8) begin
            miscompares++;
            $display("FAIL stall_hold k%0d: valid=%0b sample=%h id=%0d rdy=%b cnt=%0d, required 1 abcd0001 1 0000 8",
                     k, bus.out_valid, bus.out_sample, bus.out_id, bus.req_ready, grant_count);
         end
         step();
      end
      bus.out_ready = 1'b1;
      step();
      #1;
      vectors++;
      if (grant_count !== 32'd9 || bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0100) begin
         miscompares++;
         $display("FAIL stall_release: cnt=%0d valid=%0b rdy=%b, required 9 0 0100",
                  grant_count, bus.out_valid, bus.req_ready);
      end
      step();
      bus.req_valid = '0;
      vectors++;
      if (bus.out_id !== 2'd2 || bus.out_sample !== 32'hABCD_0002) begin
         miscompares++;
         $display("FAIL stall_next: id=%0d sample=%h, required 2 abcd0002", bus.out_id, bus.out_sample);
      end
      step();
      vectors++;
      if (grant_count !== 32'd10) begin
         miscompares++;
         $display("FAIL stall_count: grant_count=%0d, required 10", grant_count);
      end
   endtask

   task automatic test_clip_neg();
      int c;
      bus.req_sample[127:96]  = 32'd7;
      bus.req_latency[127:96] = 32'hFFFF_FFFB;
      bus.req_valid = 4'b1000;
      wait_grant(4, c);
      vectors++;
      if (bus.req_ready !== 4'b1000) begin
         miscompares++;
         $display("FAIL neg_grant: req_ready=%b, required 1000", bus.req_ready);
      end
      step();
      bus.req_valid = '0;
      vectors++;
      if (bus.out_latency !== 16'd0 || bus.out_sample !== 32'd7 || bus.out_id !== 2'd3) begin
         miscompares++;
         $display("FAIL neg_out: lat=%0d sample=%0d id=%0d, required 0 7 3",
                  bus.out_latency, bus.out_sample, bus.out_id);
      end
      step();
      vectors++;
      if (state_dbg !== S_ARB || grant_count !== 32'd11) begin
         miscompares++;
         $display("FAIL neg_nogap: state=%0d cnt=%0d, required 0 11", state_dbg, grant_count);
      end
   endtask

   task automatic test_clip_sat();
      int c, n;
      bus.req_sample[31:0]  = 32'd9;
      bus.req_latency[31:0] = 32'h0001_0000;
      bus.req_valid = 4'b0001;
      wait_grant(4, c);
      step();
      bus.req_valid = '0;
      vectors++;
      if (bus.out_latency !== 16'hFFFF || bus.out_id !== 2'd0) begin
         miscompares++;
         $display("FAIL sat_out: lat=%h id=%0d, required ffff 0", bus.out_latency, bus.out_id);
      end
      step();
      n = 0;
      while (state_dbg == S_GAP && n < 70000) begin
         n++;
         step();
      end
      vectors++;
      if (n != 65535 || state_dbg !== S_ARB) begin
         miscompares++;
         $display("FAIL sat_gap: %0d GAP cycles state=%0d, required 65535 0", n, state_dbg);
      end
      vectors++;
      if (grant_count !== 32'd12) begin
         miscompares++;
         $display("FAIL sat_count: grant_count=%0d, required 12", grant_count);
      end
      bus.req_latency[31:0] = 32'd0;
   endtask

   task automatic test_done();
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pre: done=%0b, required 0", done);
      end
      bus.req_valid = '0;
      bus.req_done  = 4'b1111;
      step();
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL done_set: done=%0b, required 1", done);
      end
      en = 1'b0;
      step();
      en = 1'b1;
      bus.req_done = 4'b0000;
      step();
      bus.req_done = 4'b0101;
      en = 1'b0;
      step();
      en = 1'b1;
      step();
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL done_sticky: done=%0b, required 1", done);
      end
      bus.req_done = '0;
   endtask

   task automatic test_async_reset_gap();
      int c;
      bus.req_sample[95:64]  = 32'h55;
      bus.req_latency[95:64] = 32'd20;
      bus.req_valid = 4'b0100;
      wait_grant(4, c);
      vectors++;
      if (bus.req_ready !== 4'b0100) begin
         miscompares++;
         $display("FAIL ar_grant: req_ready=%b, required 0100", bus.req_ready);
      end
      step();
      bus.req_valid = '0;
      step();
      step();
      step();
      vectors++;
      if (state_dbg !== S_GAP || grant_count !== 32'd13) begin
         miscompares++;
         $display("FAIL ar_ingap: state=%0d cnt=%0d, required 2 13", state_dbg, grant_count);
      end
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_latency[32*i +: 32] = 32'd0;
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.out_valid, bus.out_sample, bus.out_latency, bus.out_id, grant_count, done,
           bus.req_ready, state_dbg} !== '0) begin
         miscompares++;
         $display("FAIL ar_values: valid=%0b sample=%h lat=%h id=%0d cnt=%0d done=%0b rdy=%b st=%0d, required all 0",
                  bus.out_valid, bus.out_sample, bus.out_latency, bus.out_id, grant_count, done,
                  bus.req_ready, state_dbg);
      end
      step();
      rst_n = 1'b1;
      bus.req_valid = 4'b1111;
      wait_grant(4, c);
      vectors++;
      if (bus.req_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL ar_first: req_ready=%b, required 0001", bus.req_ready);
      end
      step();
      vectors++;
      if (bus.out_id !== 2'd0) begin
         miscompares++;
         $display("FAIL ar_first_id: out_id=%0d, required 0", bus.out_id);
      end
      proto_en = 1'b0;
      bus.req_valid = '0;
      step();
      step();
      proto_en = 1'b1;
   endtask

   initial begin
      bus.req_valid   = '0;
      bus.req_sample  = '0;
      bus.req_latency = '0;
      bus.req_done    = '0;
      bus.out_ready   = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_clip_neg();
      test_clip_sat();
      test_done();
      test_async_reset_gap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
